// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types for the unified I/D memory port arbiter
//
// Purpose: owner encoding and read-tag record used to steer SRAM read data
//          back to the fetch (IF) or data (D) requester, plus the maximum
//          supported SRAM read latency.
// Ports:   none (package).
package riscv_mem_pkg;

  localparam int MEM_LAT_MAX = 4;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request/response and SRAM bus bundle for the arbiter
//
// Purpose: groups the IF port, D port and SRAM command/data signals.
// Modports:
//   master - pipeline + SRAM side: drives requests and mem_rdata,
//            receives grants, read data and the SRAM command.
//   slave  - arbiter side: the mirror image of master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [DATA_W/8-1:0]   d_be;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/rd_tag_pipe.sv
// rtl/rd_tag_pipe.sv - MEM_LAT-deep shift register of in-flight read tags
//
// Purpose: delays the {valid, owner} tag of each issued read so that it
//          lines up with the SRAM read data MEM_LAT cycles later.
// Ports:
//   clk     - rising-edge clock
//   reset   - asynchronous active-low clear (drops all in-flight tags)
//   tag_in  - tag captured into stage 0 on each clock
//   tag_out - last stage, aligned with mem_rdata
module rd_tag_pipe
  import riscv_mem_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t tag_q [MEM_LAT];
  rd_tag_t tag_d [MEM_LAT];

  always_comb begin
    tag_d[0] = tag_in;
    for (int i = 1; i < MEM_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q <= tag_d;
    end
  end

  assign tag_out = tag_q[MEM_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port unified SRAM arbiter for IF and MEM stages
//
// Purpose: issues at most one SRAM command per cycle, choosing between the
//          fetch (IF) and data (D) requesters; D wins conflicts unless IF has
//          been denied STARVE_MAX cycles in a row. Read returns are steered
//          to their issuer through a tag pipeline.
// Ports:
//   clk          - rising-edge clock
//   reset        - asynchronous active-low reset
//   bus          - mem_port_arbiter_if.slave: IF/D requests, grants, read
//                  data and the SRAM command/read-data bus
//   conflict_cnt - saturating count of cycles with both requests high
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic [15:0]         conflict_cnt
);

  localparam int BE_W = DATA_W / 8;
  localparam int SW   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  if ((MEM_LAT < 1) || (MEM_LAT > MEM_LAT_MAX)) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT must be in 1..%0d", MEM_LAT_MAX);
  end
  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX must be at least 1");
  end

  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic [15:0]       conflict_cnt_q, conflict_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic    both_req;
  logic    if_wins;
  logic    if_gnt;
  logic    d_gnt;
  logic    mem_en;
  logic    mem_we;
  logic    if_rvalid;
  logic    d_rvalid;
  rd_tag_t tag_in;
  rd_tag_t tag_out;

  // Grants are gated by reset so nothing is issued while the block is held
  // in reset, even if requests are already asserted.
  always_comb begin
    both_req = bus.if_req & bus.d_req;
    if_wins  = (starve_cnt_q == SW'(STARVE_MAX));
    if_gnt   = reset & bus.if_req & (~bus.d_req | if_wins);
    d_gnt    = reset & bus.d_req & ~if_gnt;
    mem_en   = if_gnt | d_gnt;
    mem_we   = d_gnt & bus.d_we;
  end

  // Command fields hold their previous value when idle (and IF leaves the
  // write data untouched) so the SRAM inputs never toggle needlessly.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if (if_gnt) begin
      mem_addr_d = bus.if_addr;
      mem_be_d   = '1;
    end else if (d_gnt) begin
      mem_addr_d  = bus.d_addr;
      mem_wdata_d = bus.d_wdata;
      mem_be_d    = bus.d_be;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.if_req || if_gnt) begin
      starve_cnt_d = '0;
    end else if (!if_wins) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end
  end

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (both_req && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  always_comb begin
    tag_in.valid = mem_en & ~mem_we;
    tag_in.owner = d_gnt ? OWN_D : OWN_IF;
  end

  rd_tag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Read data is passed straight through on the return cycle and held after.
  always_comb begin
    if_rvalid  = tag_out.valid & (tag_out.owner == OWN_IF);
    d_rvalid   = tag_out.valid & (tag_out.owner == OWN_D);
    if_rdata_d = if_rvalid ? bus.mem_rdata : if_rdata_q;
    d_rdata_d  = d_rvalid ? bus.mem_rdata : d_rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_q   <= '0;
      conflict_cnt_q <= '0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_be_q       <= '0;
      if_rdata_q     <= '0;
      d_rdata_q      <= '0;
    end else begin
      starve_cnt_q   <= starve_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_be_q       <= mem_be_d;
      if_rdata_q     <= if_rdata_d;
      d_rdata_q      <= d_rdata_d;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_wdata = mem_wdata_d;
  assign bus.mem_be    = mem_be_d;
  assign bus.if_rvalid = if_rvalid;
  assign bus.d_rvalid  = d_rvalid;
  assign bus.if_rdata  = if_rdata_d;
  assign bus.d_rdata   = d_rdata_d;
  assign conflict_cnt  = conflict_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] mem_rdata;
  logic [15:0] cc1;
  logic [15:0] cc3;

  int checks;
  int errors;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  assign bus1.if_req = if_req;   assign bus3.if_req = if_req;
  assign bus1.if_addr = if_addr; assign bus3.if_addr = if_addr;
  assign bus1.d_req = d_req;     assign bus3.d_req = d_req;
  assign bus1.d_we = d_we;       assign bus3.d_we = d_we;
  assign bus1.d_be = d_be;       assign bus3.d_be = d_be;
  assign bus1.d_addr = d_addr;   assign bus3.d_addr = d_addr;
  assign bus1.d_wdata = d_wdata; assign bus3.d_wdata = d_wdata;
  assign bus1.mem_rdata = mem_rdata; assign bus3.mem_rdata = mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut1 (
    .clk (clk), .reset (rst_n), .bus (bus1), .conflict_cnt (cc1)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(SMAX)) u_dut3 (
    .clk (clk), .reset (rst_n), .bus (bus3), .conflict_cnt (cc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clear_inputs();
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    if_req = 1; d_req = 1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk); #1;
    checks++; if (bus1.if_gnt !== 1'b0) begin errors++; $display("FAIL reset_if_gnt act=%b exp=0", bus1.if_gnt); end
    checks++; if (bus1.d_gnt !== 1'b0) begin errors++; $display("FAIL reset_d_gnt act=%b exp=0", bus1.d_gnt); end
    checks++; if (bus1.mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en act=%b exp=0", bus1.mem_en); end
    checks++; if (bus3.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr act=%h exp=0", bus3.mem_addr); end
    checks++; if (bus3.mem_be !== 4'h0) begin errors++; $display("FAIL reset_mem_be act=%h exp=0", bus3.mem_be); end
    checks++; if (bus1.if_rdata !== 32'h0) begin errors++; $display("FAIL reset_if_rdata act=%h exp=0", bus1.if_rdata); end
    checks++; if (cc1 !== 16'h0) begin errors++; $display("FAIL reset_conflict act=%h exp=0", cc1); end
    @(negedge clk);
    rst_n = 1;
    clear_inputs();
  endtask

  task automatic test_if_read();
    idle(4);
    @(negedge clk);
    if_req = 1; if_addr = 32'h0000_0010; mem_rdata = 32'hFFFF_0000;
    #1;
    checks++; if (bus1.if_gnt !== 1'b1) begin errors++; $display("FAIL ifrd_gnt act=%b exp=1", bus1.if_gnt); end
    checks++; if (bus1.mem_en !== 1'b1) begin errors++; $display("FAIL ifrd_mem_en act=%b exp=1", bus1.mem_en); end
    checks++; if (bus1.mem_addr !== 32'h10) begin errors++; $display("FAIL ifrd_mem_addr act=%h exp=10", bus1.mem_addr); end
    checks++; if (bus1.mem_we !== 1'b0) begin errors++; $display("FAIL ifrd_mem_we act=%b exp=0", bus1.mem_we); end
    checks++; if (bus1.mem_be !== 4'hF) begin errors++; $display("FAIL ifrd_mem_be act=%h exp=f", bus1.mem_be); end
    @(negedge clk);
    clear_inputs(); mem_rdata = 32'h1234_5678;
    #1;
    checks++; if (bus1.if_rvalid !== 1'b1) begin errors++; $display("FAIL ifrd_rvalid act=%b exp=1", bus1.if_rvalid); end
    checks++; if (bus1.if_rdata !== 32'h1234_5678) begin errors++; $display("FAIL ifrd_rdata act=%h exp=12345678", bus1.if_rdata); end
    checks++; if (bus1.d_rvalid !== 1'b0) begin errors++; $display("FAIL ifrd_d_rvalid act=%b exp=0", bus1.d_rvalid); end
    checks++; if (bus1.mem_addr !== 32'h10) begin errors++; $display("FAIL ifrd_addr_hold act=%h exp=10", bus1.mem_addr); end
    @(negedge clk);
    mem_rdata = 32'h0BAD_0BAD;
    #1;
    checks++; if (bus1.if_rvalid !== 1'b0) begin errors++; $display("FAIL ifrd_rvalid_pulse act=%b exp=0", bus1.if_rvalid); end
    checks++; if (bus1.if_rdata !== 32'h1234_5678) begin errors++; $display("FAIL ifrd_rdata_hold act=%h exp=12345678", bus1.if_rdata); end
  endtask

  task automatic test_store();
    idle(4);
    @(negedge clk);
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus1.d_gnt !== 1'b1) begin errors++; $display("FAIL st_d_gnt act=%b exp=1", bus1.d_gnt); end
    checks++; if (bus1.if_gnt !== 1'b0) begin errors++; $display("FAIL st_if_gnt act=%b exp=0", bus1.if_gnt); end
    checks++; if (bus1.mem_we !== 1'b1) begin errors++; $display("FAIL st_mem_we act=%b exp=1", bus1.mem_we); end
    checks++; if (bus1.mem_be !== 4'b0011) begin errors++; $display("FAIL st_mem_be act=%b exp=0011", bus1.mem_be); end
    checks++; if (bus1.mem_addr !== 32'h100) begin errors++; $display("FAIL st_mem_addr act=%h exp=100", bus1.mem_addr); end
    checks++; if (bus1.mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_mem_wdata act=%h exp=deadbeef", bus1.mem_wdata); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      clear_inputs();
      #1;
      checks++; if ({bus1.if_rvalid, bus1.d_rvalid, bus3.if_rvalid, bus3.d_rvalid} !== 4'b0) begin
        errors++; $display("FAIL st_no_rvalid cyc=%0d act=%b exp=0000", c,
                           {bus1.if_rvalid, bus1.d_rvalid, bus3.if_rvalid, bus3.d_rvalid}); end
    end
  endtask

  task automatic test_starvation();
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if_req = 1; d_req = 1; d_we = 0; if_addr = 32'h40 + c; d_addr = 32'h800 + c;
      #1;
      checks++; if (bus1.if_gnt !== (c == 4)) begin errors++; $display("FAIL starve_if_gnt cyc=%0d act=%b exp=%b", c, bus1.if_gnt, (c == 4)); end
      checks++; if (bus1.d_gnt !== (c != 4)) begin errors++; $display("FAIL starve_d_gnt cyc=%0d act=%b exp=%b", c, bus1.d_gnt, (c != 4)); end
      if (c == 5) begin
        checks++; if (cc1 !== 16'd5) begin errors++; $display("FAIL starve_conflict act=%0d exp=5", cc1); end
      end
    end
  endtask

  task automatic test_lat3_alternating();
    logic       exp_v;
    logic       exp_own;
    idle(5);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      clear_inputs();
      if (c < 4) begin
        if_req = (c % 2 == 0); d_req = (c % 2 == 1); d_we = 0;
        if_addr = 32'h200 + 4 * c; d_addr = 32'h300 + 4 * c;
      end
      mem_rdata = 32'hA000_0000 + c;
      #1;
      exp_v = (c >= 3) && (c <= 6);
      exp_own = ((c - 3) % 2 == 1);
      checks++; if (bus3.if_rvalid !== (exp_v && !exp_own)) begin errors++; $display("FAIL lat3_if_rvalid cyc=%0d act=%b exp=%b", c, bus3.if_rvalid, exp_v && !exp_own); end
      checks++; if (bus3.d_rvalid !== (exp_v && exp_own)) begin errors++; $display("FAIL lat3_d_rvalid cyc=%0d act=%b exp=%b", c, bus3.d_rvalid, exp_v && exp_own); end
      if (exp_v && !exp_own) begin
        checks++; if (bus3.if_rdata !== mem_rdata) begin errors++; $display("FAIL lat3_if_rdata cyc=%0d act=%h exp=%h", c, bus3.if_rdata, mem_rdata); end
      end
      if (exp_v && exp_own) begin
        checks++; if (bus3.d_rdata !== mem_rdata) begin errors++; $display("FAIL lat3_d_rdata cyc=%0d act=%h exp=%h", c, bus3.d_rdata, mem_rdata); end
      end
    end
  endtask

  task automatic test_reset_mid();
    idle(5);
    @(negedge clk); if_req = 1; if_addr = 32'h20;
    @(negedge clk); clear_inputs(); d_req = 1; d_addr = 32'h24;
    @(negedge clk);
    rst_n = 0; if_req = 1; d_req = 1;
    #1;
    checks++; if ({bus3.if_gnt, bus3.d_gnt, bus3.mem_en, bus3.mem_we, bus3.if_rvalid, bus3.d_rvalid} !== 6'b0) begin
      errors++; $display("FAIL rstmid_ctrl act=%b exp=000000",
                         {bus3.if_gnt, bus3.d_gnt, bus3.mem_en, bus3.mem_we, bus3.if_rvalid, bus3.d_rvalid}); end
    checks++; if ({bus3.mem_addr, bus3.mem_wdata, bus3.mem_be} !== 68'h0) begin
      errors++; $display("FAIL rstmid_bus act=%h exp=0", {bus3.mem_addr, bus3.mem_wdata, bus3.mem_be}); end
    checks++; if ({bus3.if_rdata, bus3.d_rdata, bus1.if_rdata} !== 96'h0) begin
      errors++; $display("FAIL rstmid_rdata act=%h exp=0", {bus3.if_rdata, bus3.d_rdata, bus1.if_rdata}); end
    checks++; if ({cc1, cc3} !== 32'h0) begin errors++; $display("FAIL rstmid_conflict act=%h exp=0", {cc1, cc3}); end
    @(negedge clk);
    rst_n = 1;
    clear_inputs();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if ({bus1.if_rvalid, bus1.d_rvalid, bus3.if_rvalid, bus3.d_rvalid} !== 4'b0) begin
        errors++; $display("FAIL rstmid_no_rvalid cyc=%0d act=%b exp=0000", c,
                           {bus1.if_rvalid, bus1.d_rvalid, bus3.if_rvalid, bus3.d_rvalid}); end
      @(negedge clk);
    end
  endtask

  // Reference model: rule-level arbitration plus a queue of (due cycle, owner)
  // read returns for the MEM_LAT=3 instance.
  task automatic test_random(input int n);
    int          starve, conflict, cyc;
    int          due_q[$];
    logic        own_q[$];
    logic [31:0] last_addr, last_wdata, last_ifd, last_dd;
    logic [3:0]  last_be;
    logic        eg_if, eg_d, e_we, e_ifv, e_dv;
    logic [31:0] e_addr, e_wdata, e_ifd, e_dd;
    logic [3:0]  e_be;
    logic        hold_if, hold_d;
    apply_reset();
    starve = 0; conflict = 0; cyc = 0;
    last_addr = 0; last_wdata = 0; last_ifd = 0; last_dd = 0; last_be = 0;
    hold_if = 0; hold_d = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (!hold_if) begin if_req = ($urandom_range(0, 2) != 0); if_addr = $urandom; end
      if (!hold_d) begin
        d_req = ($urandom_range(0, 2) != 0); d_we = $urandom_range(0, 1);
        d_be = 4'($urandom); d_addr = $urandom; d_wdata = $urandom;
      end
      mem_rdata = $urandom;
      #1;
      eg_if = if_req && (!d_req || starve == SMAX);
      eg_d = d_req && !eg_if;
      e_we = eg_d && d_we;
      e_addr = eg_if ? if_addr : (eg_d ? d_addr : last_addr);
      e_wdata = eg_d ? d_wdata : last_wdata;
      e_be = eg_if ? 4'hF : (eg_d ? d_be : last_be);
      e_ifv = (due_q.size() > 0) && (due_q[0] == cyc) && !own_q[0];
      e_dv = (due_q.size() > 0) && (due_q[0] == cyc) && own_q[0];
      e_ifd = e_ifv ? mem_rdata : last_ifd;
      e_dd = e_dv ? mem_rdata : last_dd;
      checks++; if ({bus3.if_gnt, bus3.d_gnt, bus3.mem_en, bus3.mem_we} !== {eg_if, eg_d, eg_if || eg_d, e_we}) begin
        errors++; $display("FAIL rnd_ctrl cyc=%0d act=%b exp=%b", c,
                           {bus3.if_gnt, bus3.d_gnt, bus3.mem_en, bus3.mem_we}, {eg_if, eg_d, eg_if || eg_d, e_we}); end
      checks++; if ({bus3.mem_addr, bus3.mem_wdata, bus3.mem_be} !== {e_addr, e_wdata, e_be}) begin
        errors++; $display("FAIL rnd_cmd cyc=%0d act=%h exp=%h", c,
                           {bus3.mem_addr, bus3.mem_wdata, bus3.mem_be}, {e_addr, e_wdata, e_be}); end
      checks++; if ({bus3.if_rvalid, bus3.d_rvalid} !== {e_ifv, e_dv}) begin
        errors++; $display("FAIL rnd_rvalid cyc=%0d act=%b exp=%b", c, {bus3.if_rvalid, bus3.d_rvalid}, {e_ifv, e_dv}); end
      checks++; if ({bus3.if_rdata, bus3.d_rdata} !== {e_ifd, e_dd}) begin
        errors++; $display("FAIL rnd_rdata cyc=%0d act=%h exp=%h", c, {bus3.if_rdata, bus3.d_rdata}, {e_ifd, e_dd}); end
      checks++; if (cc3 !== 16'(conflict)) begin errors++; $display("FAIL rnd_conflict cyc=%0d act=%0d exp=%0d", c, cc3, conflict); end
      if (!if_req || eg_if) starve = 0; else if (starve < SMAX) starve++;
      if (if_req && d_req && conflict < 16'hFFFF) conflict++;
      if (e_ifv || e_dv) begin void'(due_q.pop_front()); void'(own_q.pop_front()); end
      if (eg_if || (eg_d && !d_we)) begin due_q.push_back(cyc + 3); own_q.push_back(eg_d); end
      last_addr = e_addr; last_wdata = e_wdata; last_be = e_be; last_ifd = e_ifd; last_dd = e_dd;
      hold_if = if_req && !eg_if;
      hold_d = d_req && !eg_d;
      cyc++;
    end
    idle(1);
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int c = 0; c < 65540; c++) begin
      @(negedge clk);
      if_req = 1; d_req = 1; d_we = 0;
    end
    #1;
    checks++; if (cc1 !== 16'hFFFF) begin errors++; $display("FAIL sat_reach act=%h exp=ffff", cc1); end
    repeat (10) @(negedge clk);
    #1;
    checks++; if (cc3 !== 16'hFFFF) begin errors++; $display("FAIL sat_hold act=%h exp=ffff", cc3); end
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mem_rdata = 0;
    test_reset();
    test_if_read();
    test_store();
    test_starvation();
    test_lat3_alternating();
    test_reset_mid();
    test_random(400);
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data SRAM between the pipeline's IF stage (fetch) and MEM stage (load/store).
- Issues at most one memory command per cycle.
- Tracks in-flight reads so each returning word is steered to the requester that issued it.
- The pipeline stalls a stage while it has a request outstanding without a grant (req & ~gnt).

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width.
- MEM_LAT, 1, SRAM read latency in cycles; legal range 1..4.
- STARVE_MAX, 4, number of consecutive denied IF cycles after which IF wins a conflict.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request (read only).
- if_addr  input  ADDR_W  fetch address.
- if_gnt  output  1  fetch command issued this cycle.
- if_rvalid  output  1  fetch data valid.
- if_rdata  output  DATA_W  fetch data.
- d_req  input  1  load/store request.
- d_we  input  1  1 = store, 0 = load.
- d_be  input  DATA_W/8  store byte enables.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_gnt  output  1  data command issued this cycle.
- d_rvalid  output  1  load data valid.
- d_rdata  output  DATA_W  load data.
- mem_en  output  1  SRAM command strobe.
- mem_we  output  1  SRAM write.
- mem_be  output  DATA_W/8  SRAM byte enables.
- mem_addr  output  ADDR_W  SRAM address.
- mem_wdata  output  DATA_W  SRAM write data.
- mem_rdata  input  DATA_W  SRAM read data, valid MEM_LAT cycles after the command.
- conflict_cnt  output  16  saturating count of cycles with if_req & d_req.

Behaviour:
- Reset (reset=0, asynchronous):
  - if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid = 0.
  - mem_be, mem_addr, mem_wdata, if_rdata, d_rdata = 0.
  - Starvation counter and conflict_cnt = 0; tag pipeline cleared.
- Grant is combinational from the request inputs and registered state, in the same cycle:
  - Only one requester active: it is granted.
  - Both requesting: d wins unless starve_cnt == STARVE_MAX, in which case if wins.
  - No request: no grant, mem_en = 0.
- Memory command (combinational) is the granted requester's fields, with mem_en = 1. IF commands drive mem_we = 0 and mem_be = all-ones.
- Idle bus: mem_addr, mem_wdata, mem_be hold their last values; no X propagation.
- starve_cnt: +1 when if_req & ~if_gnt, saturating at STARVE_MAX. Cleared when if_gnt or ~if_req.
- Tag pipeline:
  - MEM_LAT-deep shift register of {valid, owner}.
  - Stage 0 loads valid = mem_en & ~mem_we and owner = the granted requester.
  - The output stage drives if_rvalid or d_rvalid (by owner) for exactly one cycle.
  - if_rdata and d_rdata = mem_rdata when their rvalid is high; otherwise they hold.
- Writes produce no rvalid.
- Throughput: one command per cycle; back-to-back reads are fully pipelined.
- Simultaneous events:
  - A new grant in the same cycle as a read return is legal.
  - A store may issue while a prior fetch read is in flight; ordering is by issue cycle.
- conflict_cnt: +1 per cycle with if_req & d_req while not in reset; saturates at 16'hFFFF.
- Reset mid-operation: in-flight reads are discarded; no rvalid for them after reset deasserts.
- Requesters must hold req and request fields stable until granted. The arbiter does not latch ungranted requests.
- Parameter check: MEM_LAT outside 1..4 or STARVE_MAX < 1 triggers an elaboration-time $error.

Decomposition:
- Package riscv_mem_pkg holds:
  - the owner_e enum {OWN_IF, OWN_D};
  - the rd_tag_t struct {valid, owner};
  - the MEM_LAT_MAX = 4 constant.
- One sub-module, rd_tag_pipe: MEM_LAT-deep tag shift register with async active-low clear.
- Arbitration, starvation counter and conflict counter stay in the top module.

Test Plan:
- Only if_req=1, if_addr=0x0000_0010, MEM_LAT=1 → if_gnt=1 same cycle, mem_en=1, mem_addr=0x10, mem_we=0; next cycle if_rvalid=1, if_rdata=mem_rdata; d_rvalid=0.
- d_req store, d_be=4'b0011, d_wdata=0xDEAD_BEEF, addr 0x100 → d_gnt=1, mem_we=1, mem_be=4'b0011; no rvalid on either side.
- if_req and d_req both held high, d_we=0 → d granted 4 consecutive cycles; 5th cycle if_gnt=1, d_gnt=0; starve_cnt returns to 0; conflict_cnt=5.
- MEM_LAT=3, alternating IF/D reads issued in cycles 0..3 → rvalid pulses in cycles 3..6 routed IF, D, IF, D with matching data.
- Reads in flight, reset pulsed low for 1 cycle → all outputs 0 immediately; no rvalid after release; conflict_cnt=0.
- Hold both requests for 70000 cycles → conflict_cnt saturates at 0xFFFF and holds.
